pio_pattern_sequencer: RTL and testbench

- Avalon-MM slave controller that sequences a 17-bit parallel output port from a small pattern FIFO.
- Software pushes output words and a per-word hold time; the block replays them back-to-back on out_port with cycle-exact timing, without per-word CPU writes.
- Sits in the SOPC beside the plain output PIO and drives the same external pins class.

---
 rtl/pio_pattern_sequencer_if.sv | 11 +
 rtl/pio_pattern_sequencer.sv | 165 ++++++++++++++++
 tb/tb_pio_pattern_sequencer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pio_pattern_sequencer_if.sv
// Avalon-MM slave bus bundle for the pattern sequencer register file.
interface pio_pattern_sequencer_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pio_pattern_sequencer.sv
// Pattern sequencer: replays queued words on out_port, each for HOLD+1 cycles,
// back-to-back, under Avalon-MM register control.
module pio_pattern_sequencer #(
  parameter int DATA_WIDTH = 17,
  parameter int FIFO_DEPTH = 8,
  parameter int HOLD_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  pio_pattern_sequencer_if.slave  bus,
  output logic [DATA_WIDTH-1:0]   out_port,
  output logic                    irq
);
  // state | meaning
  // IDLE  | nothing being timed; waits for run=1 and a queued word
  // SHOW  | word on out_port, hold counter running down to 0

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t                state_q, state_d;
  logic [HOLD_WIDTH-1:0] cnt_q, cnt_d;
  logic [HOLD_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  run_q, run_d, irq_en_q, irq_en_d;
  logic                  ovf_q, ovf_d, done_q, done_d, irq_q, irq_d;

  logic wr, wr_pat, wr_hold, wr_ctrl, wr_stat, flush;
  logic empty, full, avail, pop, push_ok, done_set;
  logic [31:0] status, rdata;
  logic unused_bits;

  assign wr      = bus.chipselect & ~bus.write_n;
  assign wr_pat  = wr & (bus.address == 2'd0);
  assign wr_hold = wr & (bus.address == 2'd1);
  assign wr_ctrl = wr & (bus.address == 2'd2);
  assign wr_stat = wr & (bus.address == 2'd3);
  assign flush   = wr_ctrl & bus.writedata[2];
  assign unused_bits = ^bus.writedata;

  assign empty = (level_q == '0);
  assign full  = (level_q == DEPTH_L);
  // A flush in this cycle hides the queue from the sequencer
  assign avail = ~empty & ~flush;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    pop      = 1'b0;
    done_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (run_q && avail) begin
          pop     = 1'b1;
          out_d   = mem_q[rd_ptr_q];
          cnt_d   = hold_q;
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - HOLD_WIDTH'(1);
        end else if (!run_q) begin
          state_d = IDLE;
        end else if (avail) begin
          pop   = 1'b1;
          out_d = mem_q[rd_ptr_q];
          cnt_d = hold_q;
        end else begin
          state_d  = IDLE;
          done_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign push_ok = wr_pat & (~full | pop);

  always_comb begin
    level_d  = level_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      level_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok && !pop)      level_d = level_q + LW'(1);
      else if (pop && !push_ok) level_d = level_q - LW'(1);
    end
  end

  assign hold_d   = wr_hold ? bus.writedata[HOLD_WIDTH-1:0] : hold_q;
  assign run_d    = wr_ctrl ? bus.writedata[0] : run_q;
  assign irq_en_d = wr_ctrl ? bus.writedata[1] : irq_en_q;
  // Setting events win over a simultaneous write-1-to-clear
  assign ovf_d    = (ovf_q & ~(wr_stat & bus.writedata[16])) | (wr_pat & ~push_ok);
  assign done_d   = (done_q & ~(wr_stat & bus.writedata[17])) | done_set;
  assign irq_d    = irq_en_q & (ovf_q | done_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hold_q   <= '0;
      out_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      run_q    <= 1'b0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      out_q    <= out_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      run_q    <= run_d;
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      irq_q    <= irq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= bus.writedata[DATA_WIDTH-1:0];
  end

  always_comb begin
    status         = '0;
    status[LW-1:0] = level_q;
    status[8]      = (state_q == SHOW);
    status[9]      = empty;
    status[10]     = full;
    status[16]     = ovf_q;
    status[17]     = done_q;
    rdata          = '0;
    case (bus.address)
      2'd0:    rdata[DATA_WIDTH-1:0] = out_q;
      2'd1:    rdata[HOLD_WIDTH-1:0] = hold_q;
      2'd2:    rdata[1:0] = {irq_en_q, run_q};
      default: rdata = status;
    endcase
  end

  assign bus.readdata = rdata;
  assign out_port     = out_q;
  assign irq          = irq_q;
endmodule

// File: tb/tb_pio_pattern_sequencer.sv
// Bench for pio_pattern_sequencer: queue-based reference model checked every
// cycle, plus directed scenarios with literal expected values.
module tb_pio_pattern_sequencer;
  localparam int DW = 17;
  localparam int DEPTH = 8;
  localparam int HW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] out_port;
  logic          irq;
  int            checks = 0;
  int            failures = 0;

  pio_pattern_sequencer_if bus();

  pio_pattern_sequencer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .HOLD_WIDTH(HW)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave), .out_port(out_port), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: queue of pending words, word on display and the number
  // of cycles it still has to stay there (0 = nothing being timed).
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_out;
  int            m_rem;
  logic [HW-1:0] m_hold;
  logic          m_run, m_irq_en, m_ovf, m_done, m_irq;

  logic [DW-1:0] exp_basic [10] = '{17'h00001, 17'h00001, 17'h00001, 17'h1FFFF, 17'h1FFFF,
                                    17'h1FFFF, 17'h0AAAA, 17'h0AAAA, 17'h0AAAA, 17'h0AAAA};
  logic [DW-1:0] exp_ovf [10]   = '{17'h10, 17'h11, 17'h12, 17'h13, 17'h14,
                                    17'h15, 17'h16, 17'h17, 17'h17, 17'h17};
  logic [DW-1:0] exp_stop [13]  = '{17'h101, 17'h101, 17'h101, 17'h101, 17'h101, 17'h101,
                                    17'h102, 17'h102, 17'h102, 17'h102, 17'h102, 17'h102,
                                    17'h102};
  logic          exp_irq [7]    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_out = '0; m_rem = 0; m_hold = '0;
    m_run = 1'b0; m_irq_en = 1'b0; m_ovf = 1'b0; m_done = 1'b0; m_irq = 1'b0;
  endtask

  task automatic model_step();
    logic        w, fl, popping, irq_nx;
    logic [1:0]  a;
    logic [31:0] d;
    w  = bus.chipselect && !bus.write_n;
    a  = bus.address;
    d  = bus.writedata;
    fl = w && (a == 2'd2) && d[2];
    irq_nx = m_irq_en && (m_ovf || m_done);
    if (w && a == 2'd3) begin
      if (d[16]) m_ovf = 1'b0;
      if (d[17]) m_done = 1'b0;
    end
    popping = (m_rem <= 1) && m_run && (m_q.size() > 0) && !fl;
    if (popping) begin
      m_out = m_q.pop_front();
      m_rem = int'(m_hold) + 1;
    end else if (m_rem > 1) begin
      m_rem--;
    end else begin
      if (m_rem == 1 && m_run) m_done = 1'b1;
      m_rem = 0;
    end
    if (w && a == 2'd0) begin
      if (m_q.size() < DEPTH) m_q.push_back(d[DW-1:0]);
      else m_ovf = 1'b1;
    end
    if (fl) m_q.delete();
    if (w && a == 2'd1) m_hold = d[HW-1:0];
    if (w && a == 2'd2) begin
      m_run = d[0];
      m_irq_en = d[1];
    end
    m_irq = irq_nx;
  endtask

  function automatic logic [31:0] m_rdata(input logic [1:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0: r = 32'(m_out);
      2'd1: r = 32'(m_hold);
      2'd2: r = {30'd0, m_irq_en, m_run};
      default: begin
        r[3:0] = 4'(m_q.size());
        r[8]   = (m_rem > 0);
        r[9]   = (m_q.size() == 0);
        r[10]  = (m_q.size() == DEPTH);
        r[16]  = m_ovf;
        r[17]  = m_done;
      end
    endcase
    return r;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!reset_n) model_reset();
      else model_step();
      #2;
      if (!reset_n) model_reset();
      chk("cyc_out_port", 32'(out_port), 32'(m_out));
      chk("cyc_irq", 32'(irq), 32'(m_irq));
      chk("cyc_readdata", bus.readdata, m_rdata(bus.address));
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
    #1;
    chk(name, bus.readdata, exp);
    bus.chipselect = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    rd(2'd0, 32'h0, "rst_pattern");
    rd(2'd1, 32'h0, "rst_hold");
    rd(2'd2, 32'h0, "rst_control");
    rd(2'd3, 32'h200, "rst_status");
    chk("rst_out_port", 32'(out_port), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);

    // three words, HOLD=2: 3 cycles each, contiguous
    @(negedge clk);
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h00001);
    wr(2'd0, 32'h1FFFF);
    wr(2'd0, 32'h0AAAA);
    wr(2'd2, 32'h1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("basic_out[%0d]", i), 32'(out_port), 32'(exp_basic[i]));
    end
    @(negedge clk);
    rd(2'd3, 32'h20200, "basic_status");
    @(negedge clk);
    wr(2'd3, 32'h30000);
    wr(2'd2, 32'h0);

    // nine pushes into an 8-deep queue
    for (int i = 0; i < 9; i++) wr(2'd0, 32'h10 + 32'(i));
    rd(2'd3, 32'h10408, "ovf_status");
    @(negedge clk);
    wr(2'd1, 32'd0);
    wr(2'd2, 32'h1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("ovf_out[%0d]", i), 32'(out_port), 32'(exp_ovf[i]));
    end
    @(negedge clk);
    rd(2'd3, 32'h30200, "ovf_done_status");
    @(negedge clk);
    wr(2'd3, 32'h30000);

    // stop two cycles into the first word
    wr(2'd2, 32'h0);
    wr(2'd0, 32'h100);
    wr(2'd0, 32'h101);
    wr(2'd0, 32'h102);
    wr(2'd1, 32'd5);
    wr(2'd2, 32'h1);
    repeat (2) @(negedge clk);
    wr(2'd2, 32'h0);
    repeat (3) @(negedge clk);
    rd(2'd3, 32'h102, "stop_last_hold_cycle");
    @(negedge clk);
    rd(2'd3, 32'h002, "stop_idle_status");
    chk("stop_out_kept", 32'(out_port), 32'h100);
    @(negedge clk);
    wr(2'd2, 32'h1);
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      chk($sformatf("stop_resume_out[%0d]", i), 32'(out_port), 32'(exp_stop[i]));
    end
    @(negedge clk);
    rd(2'd3, 32'h20200, "stop_done_status");
    @(negedge clk);
    wr(2'd3, 32'h30000);

    // interrupt on done, then clear
    wr(2'd2, 32'h2);
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h1);
    wr(2'd0, 32'h2);
    wr(2'd2, 32'h3);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      chk($sformatf("irq_seq[%0d]", i), 32'(irq), 32'(exp_irq[i]));
    end
    @(negedge clk);
    wr(2'd3, 32'h20000);
    chk("irq_still_registered", 32'(irq), 32'h1);
    @(negedge clk);
    chk("irq_cleared", 32'(irq), 32'h0);

    // flush while a word is on display
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h11);
    wr(2'd0, 32'h12);
    wr(2'd0, 32'h13);
    wr(2'd0, 32'h14);
    wr(2'd2, 32'h7);
    rd(2'd3, 32'h300, "flush_status");
    chk("flush_out", 32'(out_port), 32'h11);
    repeat (2) @(negedge clk);
    rd(2'd3, 32'h300, "flush_hold_last");
    chk("flush_out_held", 32'(out_port), 32'h11);
    @(negedge clk);
    rd(2'd3, 32'h20200, "flush_done_status");

    // asynchronous reset between edges mid-SHOW
    @(negedge clk);
    wr(2'd0, 32'h1ABCD);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_out_port", 32'(out_port), 32'h0);
    chk("arst_irq", 32'(irq), 32'h0);
    bus.address = 2'd3;
    #1;
    chk("arst_status", bus.readdata, 32'h200);
    @(negedge clk);
    reset_n = 1'b1;
    rd(2'd2, 32'h0, "arst_control");
    rd(2'd1, 32'h0, "arst_hold");
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
